// File: rtl/head_seq_if.sv
// rtl/head_seq_if.sv - signal bundle between head_seq and its memories, operand buffers and engine
interface head_seq_if #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int IAW = 8,
  parameter int WAW = 10
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  // control / status
  logic           start;
  logic           busy;
  logic           done;
  logic           err;
  logic [IAW-1:0] pc;

  // instruction memory read port
  logic [IAW-1:0] i_addr;
  logic [15:0]    i_data;

  // weight memory port
  logic [WAW-1:0] w_addr;
  logic [DW-1:0]  w_rdata;
  logic [DW-1:0]  w_wdata;
  logic           w_we;

  // operand buffer write port
  logic           ld_lef;
  logic           ld_rig;
  logic [RW-1:0]  ld_row;
  logic [RW-1:0]  ld_col;
  logic [DW-1:0]  ld_data;

  // matrix engine
  logic           mul_start;
  logic           mul_done;
  logic [RW-1:0]  res_row;
  logic [RW-1:0]  res_col;
  logic [DW-1:0]  res_data;

  modport master (
    input  start, i_data, w_rdata, mul_done, res_data,
    output busy, done, err, pc, i_addr, w_addr, w_wdata, w_we,
           ld_lef, ld_rig, ld_row, ld_col, ld_data, mul_start, res_row, res_col
  );

  modport slave (
    output start, i_data, w_rdata, mul_done, res_data,
    input  busy, done, err, pc, i_addr, w_addr, w_wdata, w_we,
           ld_lef, ld_rig, ld_row, ld_col, ld_data, mul_start, res_row, res_col
  );
endinterface

// File: rtl/head_seq.sv
// rtl/head_seq.sv - instruction sequencer: fetch/decode, tile load/store, engine launch, one-level loop
module head_seq #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int IAW = 8,
  parameter int WAW = 10
) (
  input  logic      clk,
  input  logic      rst,
  head_seq_if.master bus
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_LDL  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_STO  = 4'h4;
  localparam logic [3:0] OP_LPS  = 4'h5;
  localparam logic [3:0] OP_LPE  = 4'h6;
  localparam logic [3:0] OP_NOP  = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD, S_MUL, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IAW-1:0] pc_q, pc_d;
  logic [WAW-1:0] base_q, base_d;
  logic           right_q, right_d;
  logic           err_q, err_d;
  logic           loop_act_q, loop_act_d;
  logic [IAW-1:0] loop_pc_q, loop_pc_d;
  logic [11:0]    loop_cnt_q, loop_cnt_d;

  logic [3:0]     op;
  logic [11:0]    arg;
  logic [IAW-1:0] pc_inc;
  logic [WAW-1:0] base_w;
  logic [CW-1:0]  ld_idx;
  logic [WAW-1:0] elem_addr;

  assign op        = bus.i_data[3:0];
  assign arg       = bus.i_data[15:4];
  assign pc_inc    = pc_q + IAW'(1);
  // Tile base wraps naturally by truncating to the weight address width.
  assign base_w    = WAW'(32'(arg) * 32'(NN));
  // Load strobes trail the read address by one cycle, so they report the previous index.
  assign ld_idx    = cnt_q - CW'(1);
  assign elem_addr = base_q + WAW'(cnt_q);

  // State and datapath registers; reset aborts any tile transfer immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      base_q     <= '0;
      right_q    <= 1'b0;
      err_q      <= 1'b0;
      loop_act_q <= 1'b0;
      loop_pc_q  <= '0;
      loop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      base_q     <= base_d;
      right_q    <= right_d;
      err_q      <= err_d;
      loop_act_q <= loop_act_d;
      loop_pc_q  <= loop_pc_d;
      loop_cnt_q <= loop_cnt_d;
    end
  end

  // Next state: dispatch on the decoded opcode and sequence the per-state counters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    base_d     = base_q;
    right_d    = right_q;
    err_d      = err_q;
    loop_act_d = loop_act_q;
    loop_pc_d  = loop_pc_q;
    loop_cnt_d = loop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          loop_act_d = 1'b0;
          loop_pc_d  = '0;
          loop_cnt_d = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        base_d = base_w;
        cnt_d  = '0;
        case (op)
          OP_HALT: state_d = S_DONE;
          OP_LDL, OP_LDR: begin
            state_d = S_LOAD;
            right_d = (op == OP_LDR);
          end
          OP_MUL: state_d = S_MUL;
          OP_STO: state_d = S_STORE;
          OP_LPS: begin
            if (loop_act_q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d    = S_FETCH;
              loop_act_d = 1'b1;
              loop_pc_d  = pc_inc;
              loop_cnt_d = (arg == 12'd0) ? 12'd1 : arg;
              pc_d       = pc_inc;
            end
          end
          OP_LPE: begin
            state_d = S_FETCH;
            if (loop_act_q && (loop_cnt_q > 12'd1)) begin
              loop_cnt_d = loop_cnt_q - 12'd1;
              pc_d       = loop_pc_q;
            end else begin
              loop_act_d = 1'b0;
              loop_cnt_d = '0;
              pc_d       = pc_inc;
            end
          end
          OP_NOP: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end
          default: begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        endcase
      end
      S_LOAD: begin
        if (cnt_q == CW'(NN)) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          pc_d    = pc_inc;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MUL: begin
        // cnt_q marks the launch cycle so a stale done in that cycle is ignored.
        if (cnt_q == '0) begin
          cnt_d = CW'(1);
        end else if (bus.mul_done) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          pc_d    = pc_inc;
        end
      end
      S_STORE: begin
        if (cnt_q == CW'(NN - 1)) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          pc_d    = pc_inc;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes, addresses and data decoded from state and counter, zero when idle.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.err       = err_q;
    bus.pc        = pc_q;
    bus.i_addr    = pc_q;
    bus.w_addr    = '0;
    bus.w_wdata   = {DW{1'b0}};
    bus.w_we      = 1'b0;
    bus.ld_lef    = 1'b0;
    bus.ld_rig    = 1'b0;
    bus.ld_row    = '0;
    bus.ld_col    = '0;
    bus.ld_data   = {DW{1'b0}};
    bus.mul_start = 1'b0;
    bus.res_row   = '0;
    bus.res_col   = '0;
    case (state_q)
      S_LOAD: begin
        if (cnt_q != CW'(NN)) begin
          bus.w_addr = elem_addr;
        end
        if (cnt_q != '0) begin
          bus.ld_lef  = ~right_q;
          bus.ld_rig  = right_q;
          bus.ld_row  = RW'(ld_idx / CW'(N));
          bus.ld_col  = RW'(ld_idx % CW'(N));
          bus.ld_data = bus.w_rdata;
        end
      end
      S_MUL: begin
        bus.mul_start = (cnt_q == '0);
      end
      S_STORE: begin
        bus.res_row = RW'(cnt_q / CW'(N));
        bus.res_col = RW'(cnt_q % CW'(N));
        bus.w_addr  = elem_addr;
        bus.w_wdata = bus.res_data;
        bus.w_we    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_head_seq.sv
// tb/tb_head_seq.sv - randomized self-checking bench for head_seq against an instruction-level model
module tb_head_seq;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int IAW = 8;
  localparam int WAW = 10;
  localparam int NN  = N * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  head_seq_if #(.N(N), .DW(DW), .IAW(IAW), .WAW(WAW)) bus ();
  head_seq #(.N(N), .DW(DW), .IAW(IAW), .WAW(WAW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // environment: instruction ROM, weight RAM, engine with programmable latency
  logic [15:0]   imem [0:255];
  logic [DW-1:0] wmem [0:1023];
  logic          mem_init;
  int            lat;
  logic [3:0]    mrem;

  function automatic logic [DW-1:0] res_val(input int r, input int c);
    return DW'(32'hA000 + r * 37 + c * 5);
  endfunction

  always @(posedge clk) bus.i_data <= imem[bus.i_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 1024; k++) wmem[k] <= DW'(k);
    end else if (bus.w_we) begin
      wmem[bus.w_addr] <= bus.w_wdata;
    end
    bus.w_rdata <= wmem[bus.w_addr];
  end

  always @(posedge clk) begin
    if (rst) mrem <= 4'd0;
    else if (bus.mul_start) mrem <= 4'(lat);
    else if (mrem != 4'd0) mrem <= mrem - 4'd1;
  end
  assign bus.mul_done = (mrem == 4'd1);
  assign bus.res_data = res_val(int'(bus.res_row), int'(bus.res_col));

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // instruction-level reference model
  typedef struct { bit right; int row; int col; int data; } ld_t;
  typedef struct { int addr; int data; } wr_t;
  ld_t exp_ld[$];
  wr_t exp_wr[$];
  int  mdl_mem [0:1023];
  int  exp_end, exp_pc, exp_mul;
  bit  exp_err;

  task automatic model_run();
    int pc, lpc, lcnt, cyc, steps, op, arg, base, a;
    bit lact, fin;
    logic [15:0] ins;
    pc = 0; lpc = 0; lcnt = 0; cyc = 0; steps = 0; lact = 0; fin = 0;
    exp_ld.delete(); exp_wr.delete(); exp_mul = 0; exp_err = 0;
    while (!fin && steps < 5000) begin
      ins  = imem[pc];
      op   = int'(ins[3:0]);
      arg  = int'(ins[15:4]);
      base = (arg * NN) % 1024;
      steps++;
      cyc += 2;
      case (op)
        0: fin = 1;
        1, 2: begin
          for (int k = 0; k < NN; k++)
            exp_ld.push_back('{op == 2, k / N, k % N, mdl_mem[(base + k) % 1024]});
          cyc += NN + 1;
          pc = (pc + 1) % 256;
        end
        3: begin exp_mul++; cyc += 1 + lat; pc = (pc + 1) % 256; end
        4: begin
          for (int k = 0; k < NN; k++) begin
            a = (base + k) % 1024;
            exp_wr.push_back('{a, int'(res_val(k / N, k % N))});
            mdl_mem[a] = int'(res_val(k / N, k % N));
          end
          cyc += NN;
          pc = (pc + 1) % 256;
        end
        5: begin
          if (lact) begin exp_err = 1; fin = 1; end
          else begin lact = 1; lpc = (pc + 1) % 256; lcnt = (arg == 0) ? 1 : arg; pc = (pc + 1) % 256; end
        end
        6: begin
          if (lact && lcnt > 1) begin lcnt--; pc = lpc; end
          else begin lact = 0; pc = (pc + 1) % 256; end
        end
        7: pc = (pc + 1) % 256;
        default: begin exp_err = 1; fin = 1; end
      endcase
    end
    exp_end = cyc;
    exp_pc  = pc;
  endtask

  // per-cycle compare process against the model
  int  cyc;
  bit  mon_en = 0;
  int  got_mul;
  ld_t e_ld;
  wr_t e_wr;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (cyc >= -1 && cyc <= exp_end + 1) begin
        chk("busy", bus.busy, (cyc >= 0 && cyc <= exp_end));
        chk("done", bus.done, (cyc == exp_end && !exp_err));
        if (cyc >= 0 && cyc < exp_end) chk("err_run", bus.err, 0);
        if (cyc == exp_end) begin
          chk("err_end", bus.err, exp_err);
          chk("pc_end", bus.pc, exp_pc);
        end
      end
      if (bus.ld_lef || bus.ld_rig) begin
        if (exp_ld.size() == 0) chk("ld_extra", 1, 0);
        else begin
          e_ld = exp_ld.pop_front();
          chk("ld", (64'(bus.ld_rig) << 40) | (64'(bus.ld_lef) << 36) | (64'(bus.ld_row) << 28) |
                    (64'(bus.ld_col) << 20) | 64'(bus.ld_data),
                    (64'(e_ld.right) << 40) | (64'(!e_ld.right) << 36) | (64'(e_ld.row) << 28) |
                    (64'(e_ld.col) << 20) | 64'(e_ld.data));
        end
      end
      if (bus.w_we) begin
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e_wr = exp_wr.pop_front();
          chk("wr", (64'(bus.w_addr) << 20) | 64'(bus.w_wdata),
                    (64'(e_wr.addr) << 20) | 64'(e_wr.data));
        end
      end
      if (bus.mul_start) got_mul++;
    end
  end

  task automatic run_dut();
    @(posedge clk); #2;
    bus.start = 1'b1; cyc = -2; got_mul = 0; mon_en = 1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (int t = 0; t < exp_end + 8 && cyc < exp_end + 1; t++) @(posedge clk);
    #2;
    mon_en = 0;
    chk("ld_left", exp_ld.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("mul_cnt", got_mul, exp_mul);
  endtask

  task automatic run_prog();
    model_run();
    run_dut();
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) imem[k] = 16'h0000;
  endtask

  task automatic init_mem();
    @(posedge clk); #2;
    mem_init = 1'b1;
    @(posedge clk); #2;
    mem_init = 1'b0;
    for (int k = 0; k < 1024; k++) mdl_mem[k] = k;
  endtask

  task automatic load_prog1();
    clear_prog();
    imem[0] = 16'h0011; imem[1] = 16'h0022; imem[2] = 16'h0003;
    imem[3] = 16'h0034; imem[4] = 16'h0000;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int n, r, len, op, arg;

  initial begin
    clear_prog();
    rst = 1'b1; bus.start = 1'b1; mem_init = 1'b0; lat = 1;

    // reset with start held: everything quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_strobes", {bus.w_we, bus.ld_lef, bus.ld_rig, bus.mul_start}, 0);
    chk("rst_pc", {bus.pc, bus.i_addr}, 0);
    chk("rst_waddr", {bus.w_addr, bus.w_wdata}, 0);
    chk("rst_ld", {bus.ld_row, bus.ld_col, bus.ld_data}, 0);
    chk("rst_res", {bus.res_row, bus.res_col}, 0);
    rst = 1'b0; bus.start = 1'b0;
    init_mem();
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // reference program
    lat = 3;
    load_prog1();
    model_run();
    chk("pin_p1_end", exp_end, 61 + lat);
    chk("pin_p1_ldn", exp_ld.size(), 32);
    chk("pin_p1_ld0", exp_ld[0].data, 16);
    chk("pin_p1_ld31", {exp_ld[31].right, 16'(exp_ld[31].data)}, {1'b1, 16'd47});
    chk("pin_p1_wr0", exp_wr[0].addr, 48);
    run_dut();

    // loop three times
    lat = 1;
    clear_prog();
    imem[0] = 16'h0035; imem[1] = 16'h0011; imem[2] = 16'h0006; imem[3] = 16'h0000;
    model_run();
    chk("pin_loop_ldn", exp_ld.size(), 48);
    chk("pin_loop_end", exp_end, 67);
    run_dut();

    // loop count 0 runs once
    imem[0] = 16'h0005;
    model_run();
    chk("pin_lp0_ldn", exp_ld.size(), 16);
    run_dut();

    // illegal opcode at pc 2
    clear_prog();
    imem[0] = 16'h0007; imem[1] = 16'h0007; imem[2] = 16'h0009;
    run_prog();
    chk("ill_err", bus.err, 1);
    chk("ill_pc", bus.pc, 2);
    chk("ill_busy", bus.busy, 0);

    // nested loop start
    clear_prog();
    imem[0] = 16'h0025; imem[1] = 16'h0015;
    run_prog();
    chk("nest_err", bus.err, 1);
    chk("nest_pc", bus.pc, 1);

    // next start clears err
    lat = 2;
    load_prog1();
    run_prog();
    chk("err_cleared", bus.err, 0);

    // tile base wraps past the top of weight memory
    clear_prog();
    imem[0] = 16'h0401;
    model_run();
    chk("pin_awrap_ld0", exp_ld[0].data, 0);
    chk("pin_awrap_ld15", exp_ld[15].data, 15);
    run_dut();

    // pc wraps 255 -> 0, lands on the loop start again
    clear_prog();
    imem[0] = 16'h0015;
    for (int k = 1; k < 256; k++) imem[k] = 16'h0007;
    model_run();
    chk("pin_pwrap_end", exp_end, 514);
    run_dut();
    chk("pwrap_pc", bus.pc, 0);
    chk("pwrap_err", bus.err, 1);

    // randomized programs
    for (int p = 0; p < 25; p++) begin
      clear_prog();
      lat = $urandom_range(1, 5);
      len = $urandom_range(2, 7);
      for (int i = 0; i < len; i++) begin
        r   = $urandom_range(0, 99);
        arg = $urandom_range(0, 4095);
        if (r < 20) op = 1;
        else if (r < 40) op = 2;
        else if (r < 55) op = 3;
        else if (r < 70) op = 4;
        else if (r < 78) begin op = 5; arg = $urandom_range(0, 3); end
        else if (r < 88) op = 6;
        else if (r < 96) op = 7;
        else op = $urandom_range(8, 15);
        imem[i] = {12'(arg), 4'(op)};
      end
      run_prog();
    end

    // reset in the middle of a store
    clear_prog();
    imem[0] = 16'h0034;
    @(posedge clk); #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    for (int t = 0; t < 60 && n < 5; t++) begin
      @(negedge clk);
      if (bus.w_we) n++;
    end
    chk("pre_rst_writes", n, 5);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_we", bus.w_we, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_pc", bus.pc, 0);
    end
    rst = 1'b0;
    init_mem();
    lat = 4;
    load_prog1();
    run_prog();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/head_seq.md
# head_seq

Parametrised instruction sequencer for the lvg head: fetches 16-bit instructions from instruction memory, streams N×N operand tiles from weight memory into the left/right operand buffers, launches the matrix engine, writes result tiles back to weight memory, and supports one level of hardware looping. It replaces the fixed 4×4 hard-wired fetch/decode path; `head` instantiates it between `instrMem`, `weightMem` and `_lvg`.

## Interface
- `N`, 4: tile dimension; tiles are N×N words.
- `DW`, 16: weight/data word width.
- `IAW`, 8: instruction address width.
- `WAW`, 10: weight memory address width.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin execution at pc 0; ignored while `busy`.
- `busy` out 1: high from cycle after accepted `start` until `done`/`err` cycle inclusive.
- `done` out 1: one-cycle pulse on HALT.
- `err` out 1: sticky; set on illegal opcode or nested loop start; cleared by `start` or `rst`.
- `pc` out IAW: current instruction address.
- `i_addr` out IAW, `i_data` in 16: instruction read port, 1-cycle read latency.
- `w_addr` out WAW, `w_rdata` in DW (1-cycle latency), `w_wdata` out DW, `w_we` out 1: weight memory port.
- `ld_lef`, `ld_rig` out 1: write strobe into left/right operand buffer.
- `ld_row`, `ld_col` out clog2(N); `ld_data` out DW: buffer write address/data.
- `mul_start` out 1: one-cycle pulse; `mul_done` in 1: engine completion.
- `res_row`, `res_col` out clog2(N); `res_data` in DW: combinational result read.

## Operation
- Instruction: opcode = `i_data[3:0]`, arg = `i_data[15:4]`. Tile base = arg·N·N, truncated to WAW bits; element address = base + row·N + col, modulo 2^WAW.
- Opcodes: 0x0 HALT; 0x1 LDL (load left tile); 0x2 LDR (load right tile); 0x3 MUL; 0x4 STO (store result tile at base); 0x5 LPS (loop start, count = arg, 0 treated as 1); 0x6 LPE (loop end); 0x7 NOP; 0x8–0xF illegal.
- States: IDLE → FETCH → DECODE → {LOAD, MUL, STORE, back to FETCH for LPS/LPE/NOP, DONE, ERR}. LOAD/MUL/STORE → FETCH. DONE, ERR → IDLE.
- FETCH: drive `i_addr = pc`. DECODE: `i_data` valid, dispatch.
- LOAD: issue N·N reads row-major, one per cycle; each returning word asserted on `ld_lef` (LDL) or `ld_rig` (LDR) one cycle later with its row/col. Exactly N·N strobes.
- MUL: pulse `mul_start` on entry, wait for `mul_done` (any latency, may be same-cycle-next).
- STORE: N·N cycles, drive `res_row/res_col` row-major, `w_wdata = res_data`, `w_we = 1`, `w_addr` = element address.
- LPS: if loop active → ERR; else loop_pc = pc+1, loop_cnt = count, loop active. LPE: if inactive → treated as NOP; if loop_cnt > 1 → loop_cnt−1, pc = loop_pc; else loop inactive, pc+1.
- pc increments modulo 2^IAW (wraps to 0).
- Illegal opcode: ERR, `err` set, pc holds offending address.

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `w_we`, `ld_lef`, `ld_rig`, `mul_start` = 0; `pc`, `i_addr`, `w_addr`, `w_wdata`, `ld_*`, `res_*` = 0; loop inactive, loop_cnt = 0.
- `rst` mid-operation aborts any in-flight load/store on the same edge; no further strobes after the reset edge.
- Per instruction: FETCH 1 + DECODE 1 cycle. LDL/LDR: +N·N+1 cycles. STO: +N·N. MUL: +1 + engine latency. LPS/LPE/NOP: 0 extra.
- HALT: `done` high in the DONE cycle, `busy` drops the next cycle.
- `start` and `rst` same cycle: `rst` wins.
- `start` in the DONE/ERR cycle ignored; accepted from IDLE only.

## Test plan
- Reset: assert `rst` 3 cycles with `start`=1 → all outputs 0, state IDLE, `busy` 0.
- N=4, program {0x0011 LDL 1, 0x0022 LDR 2, 0x0003 MUL, 0x0034 STO 3, 0x0000 HALT}, weight mem[k]=k → 16 `ld_lef` strobes with data 16..31, 16 `ld_rig` with 32..47, one `mul_start`, 16 writes to addresses 48..63, one `done`; total 2·5 + 17 + 17 + 1+lat + 16 cycles.
- Loop: {0x0035 LPS 3, 0x0011 LDL 1, 0x0006 LPE, 0x0000} → exactly 48 `ld_lef` strobes, then `done`; LPS with arg 0 → body runs once.
- Errors: opcode 0x9 at pc 2 → `err`=1, `pc`=2, no `done`; nested LPS → `err`; next `start` clears `err`.
- Wrap: WAW=6, LDL arg 4 (base 64) → reads addresses 0..15; pc at 255 (IAW=8) with NOP → next fetch at 0.
- Reset mid-STORE after 5 writes → no `w_we` after reset edge; new `start` runs from pc 0.
